// File: rtl/result_store.sv
// Result store: keeps up to DATADEPTH finished calculation results and lets a
// consumer step through the stored words one at a time. Reads do not consume
// entries; the read pointer cycles over the words currently stored.
module result_store #(
  parameter int DATAWIDTH = 8,
  parameter int DATADEPTH = 16,
  parameter int ADDRWIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 rd_next,
  input  logic                 clear,
  output logic                 read_en,
  output logic [DATAWIDTH-1:0] ram_dout,
  output logic [ADDRWIDTH-1:0] rd_addr,
  output logic [ADDRWIDTH:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow
);

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  localparam logic [ADDRWIDTH:0]   DEPTH_C = (ADDRWIDTH+1)'(DATADEPTH);
  localparam logic [ADDRWIDTH-1:0] LAST_C  = ADDRWIDTH'(DATADEPTH - 1);

  logic [DATAWIDTH-1:0] mem_q [DATADEPTH];

  state_t               state_q;
  logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRWIDTH:0]   count_q, count_d;
  logic [ADDRWIDTH:0]   rd_inc;
  logic [ADDRWIDTH-1:0] rd_addr_q;
  logic [DATAWIDTH-1:0] ram_dout_q;
  logic                 read_en_q;
  logic                 overflow_q;
  logic                 full_c, empty_c, wr_accept;

  // Status flags and pointer next-values. The read wrap compares against the
  // pre-write count, so a write landing in the FETCH cycle does not extend
  // the current pass over the stored words.
  always_comb begin
    full_c    = (count_q == DEPTH_C);
    empty_c   = (count_q == '0);
    wr_accept = wr_valid && !full_c;
    wr_ptr_d  = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + ADDRWIDTH'(1);
    count_d   = count_q + (ADDRWIDTH+1)'(1);
    rd_inc    = {1'b0, rd_ptr_q} + (ADDRWIDTH+1)'(1);
    rd_ptr_d  = (rd_inc == count_q) ? '0 : rd_inc[ADDRWIDTH-1:0];
  end

  // Storage array: written only for accepted words, never reset.
  always_ff @(posedge clk) begin
    if (!rst && !clear && wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Write/read control and the IDLE/FETCH read sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      read_en_q  <= 1'b0;
      overflow_q <= 1'b0;
      ram_dout_q <= '0;
      rd_addr_q  <= '0;
    end else if (clear) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      read_en_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      read_en_q <= 1'b0;

      if (wr_valid) begin
        if (!full_c) begin
          wr_ptr_q <= wr_ptr_d;
          count_q  <= count_d;
        end else begin
          overflow_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (rd_next && !empty_c) begin
            rd_addr_q <= rd_ptr_q;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          ram_dout_q <= mem_q[rd_addr_q];
          read_en_q  <= 1'b1;
          rd_ptr_q   <= rd_ptr_d;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_en  = read_en_q;
  assign ram_dout = ram_dout_q;
  assign rd_addr  = rd_addr_q;
  assign count    = count_q;
  assign full     = full_c;
  assign empty    = empty_c;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_result_store.sv
// Bench for result_store: directed stimulus pushes expected read results into
// a scoreboard; a monitor pops and compares whenever read_en is seen.
module tb_result_store;

  logic       clk = 1'b0;
  logic       rst, wr_valid, rd_next, clear;
  logic [7:0] wr_data;
  logic       read_en, full, empty, overflow;
  logic [7:0] ram_dout;
  logic [3:0] rd_addr;
  logic [4:0] count;

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  addr;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  result_store #(.DATAWIDTH(8), .DATADEPTH(16), .ADDRWIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .rd_next  (rd_next),
    .clear    (clear),
    .read_en  (read_en),
    .ram_dout (ram_dout),
    .rd_addr  (rd_addr),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: every read_en pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (read_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_read_en: read_en=1 at cycle %0d, required 0 (no request pending)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ram_dout", 32'(ram_dout), 32'(e.data));
        chk("rd_addr", 32'(rd_addr), 32'(e.addr));
        chk("read_latency", cyc, e.cyc);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] d, input logic [3:0] a);
    sb.push_back('{data: d, addr: a, cyc: cyc + 2});
    rd_next = 1'b1;
    tick();
    rd_next = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; rd_next = 1'b1; clear = 1'b0; wr_data = '0;
    tick();
    tick();
    rst = 1'b0; rd_next = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_ram_dout", 32'(ram_dout), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_read_en", 32'(read_en), 32'd0);

    // rd_next while empty is ignored
    rd_next = 1'b1; tick(); rd_next = 1'b0; tick(); tick();
    chk("empty_rd_ram_dout", 32'(ram_dout), 32'd0);

    // three words, four reads wrapping back to the first
    do_write(8'h11); do_write(8'h22); do_write(8'h33);
    chk("three_count", 32'(count), 32'd3);
    do_read(8'h11, 4'd0);
    do_read(8'h22, 4'd1);
    do_read(8'h33, 4'd2);
    do_read(8'h11, 4'd0);

    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_count", 32'(count), 32'd0);

    // seventeen writes: the last one overflows and is dropped
    for (int i = 0; i < 17; i++) do_write(8'(i));
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_overflow", 32'(overflow), 32'd1);
    chk("fill_empty", 32'(empty), 32'd0);
    for (int i = 0; i < 16; i++) do_read(8'(i), 4'(i));
    do_read(8'h00, 4'd0);

    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear2_overflow", 32'(overflow), 32'd0);

    // write during FETCH: read returns word 1, rd_ptr wraps on old count
    do_write(8'hA0); do_write(8'hA1);
    do_read(8'hA0, 4'd0);
    sb.push_back('{data: 8'hA1, addr: 4'd1, cyc: cyc + 2});
    rd_next = 1'b1; tick(); rd_next = 1'b0;
    wr_valid = 1'b1; wr_data = 8'hA2; tick(); wr_valid = 1'b0;
    tick();
    chk("fetchwr_count", 32'(count), 32'd3);
    do_read(8'hA0, 4'd0);
    do_read(8'hA1, 4'd1);
    do_read(8'hA2, 4'd2);

    // refill to overflow, then clear together with write and read request
    for (int i = 0; i < 14; i++) do_write(8'h40 + 8'(i));
    chk("refill_overflow", 32'(overflow), 32'd1);
    clear = 1'b1; wr_valid = 1'b1; wr_data = 8'hEE; rd_next = 1'b1;
    tick();
    clear = 1'b0; wr_valid = 1'b0; rd_next = 1'b0;
    chk("clrmix_count", 32'(count), 32'd0);
    chk("clrmix_empty", 32'(empty), 32'd1);
    chk("clrmix_overflow", 32'(overflow), 32'd0);
    chk("clrmix_ram_dout", 32'(ram_dout), 32'hA2);
    chk("clrmix_rd_addr", 32'(rd_addr), 32'd2);
    tick(); tick();
    do_write(8'h77);
    do_read(8'h77, 4'd0);

    // reset during FETCH aborts the read
    do_write(8'h55);
    rd_next = 1'b1; tick(); rd_next = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstfetch_read_en", 32'(read_en), 32'd0);
    chk("rstfetch_ram_dout", 32'(ram_dout), 32'd0);
    chk("rstfetch_rd_addr", 32'(rd_addr), 32'd0);
    chk("rstfetch_count", 32'(count), 32'd0);
    chk("rstfetch_overflow", 32'(overflow), 32'd0);
    chk("rstfetch_full", 32'(full), 32'd0);
    tick(); tick(); tick();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
